// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad HH:MM entry path.
package keypad_pkg;

  typedef enum logic [2:0] {IDLE, ARM, COLLECT, VALIDATE, LOAD, ERR} state_e;
  typedef enum logic {TIME, ALARM} target_e;

  localparam logic [7:0] MAX_HOUR_BCD = 8'h23;
  localparam logic [3:0] MAX_MIN_TENS = 4'd5;
  localparam logic [2:0] NUM_DIGITS   = 3'd4;

endpackage

// File: rtl/bcd_time_check.sv
// Combinational sanity check of a 4-digit BCD HH:MM word (00:00 .. 23:59).
module bcd_time_check
  import keypad_pkg::*;
(
  input  logic [15:0] bcd_word,
  output logic        valid
);

  logic [3:0] nibble_ok;
  logic [3:0] h_tens;
  logic [3:0] m_tens;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_nibble
    assign nibble_ok[gi] = (bcd_word[4*gi +: 4] <= 4'd9);
  end

  assign h_tens = bcd_word[15:12];
  assign m_tens = bcd_word[7:4];

  // With every nibble a legal digit, the BCD hour compares numerically.
  assign valid = (&nibble_ok) &&
                 (h_tens <= 4'd2) &&
                 (bcd_word[15:8] <= MAX_HOUR_BCD) &&
                 (m_tens <= MAX_MIN_TENS);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Frames, validates and loads an HH:MM keypad entry for clock or alarm time.
// Optional abandoned-entry timeout is built when ENTRY_TIMEOUT_EN is defined.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TMO_W          = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] keypad_values,
  input  logic        shift_pulse,
  input  logic        set_time_req,
  input  logic        set_alarm_req,
  input  logic        confirm,
  input  logic        cancel,
  output logic        keypad_reset_shift,
  output logic        load_time,
  output logic        load_alarm,
  output logic [7:0]  hours_bcd,
  output logic [7:0]  minutes_bcd,
  output logic [2:0]  digit_count,
  output logic        entry_error,
  output logic        busy
);

  if (TIMEOUT_CYCLES >= (1 << TMO_W)) begin : g_bad_tmo_w
    $error("TMO_W is too narrow to count to TIMEOUT_CYCLES");
  end

  state_e      state_q, state_d;
  target_e     target_q, target_d;
  logic [2:0]  count_q, count_d;
  logic        error_q, error_d;
  logic [7:0]  hours_q, hours_d;
  logic [7:0]  minutes_q, minutes_d;
  logic        reset_shift_q, reset_shift_d;
  logic        load_time_q, load_time_d;
  logic        load_alarm_q, load_alarm_d;
  logic        busy_q, busy_d;

  logic        time_ok;
  logic        req_any;
  target_e     req_target;
  logic        tmo_hit;

  bcd_time_check u_check (
    .bcd_word (keypad_values),
    .valid    (time_ok)
  );

`ifdef ENTRY_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q + TMO_W'(1);
    if (state_q != COLLECT || shift_pulse) tmo_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  assign req_any    = set_time_req | set_alarm_req;
  assign req_target = set_time_req ? TIME : ALARM;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    count_d   = count_q;
    error_d   = error_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d  = ARM;
          target_d = req_target;
          error_d  = 1'b0;
          count_d  = '0;
        end
      end
      ARM: begin
        state_d = COLLECT;
        count_d = '0;
      end
      COLLECT: begin
        // A digit arriving with confirm is counted before validation.
        if (shift_pulse && count_q != NUM_DIGITS) count_d = count_q + 3'd1;
        if (cancel) begin
          state_d = IDLE;
        end else if (req_any) begin
          state_d  = ARM;
          target_d = req_target;
          error_d  = 1'b0;
          count_d  = '0;
        end else if (confirm) begin
          state_d = VALIDATE;
        end else if (tmo_hit) begin
          state_d = ERR;
          error_d = 1'b1;
        end
      end
      VALIDATE: begin
        if (time_ok && count_q == NUM_DIGITS) begin
          state_d   = LOAD;
          hours_d   = keypad_values[15:8];
          minutes_d = keypad_values[7:0];
        end else begin
          state_d = ERR;
          error_d = 1'b1;
        end
      end
      LOAD:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    reset_shift_d = (state_d == ARM);
    load_time_d   = (state_d == LOAD) && (target_d == TIME);
    load_alarm_d  = (state_d == LOAD) && (target_d == ALARM);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      target_q      <= TIME;
      count_q       <= '0;
      error_q       <= 1'b0;
      hours_q       <= '0;
      minutes_q     <= '0;
      reset_shift_q <= 1'b0;
      load_time_q   <= 1'b0;
      load_alarm_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      count_q       <= count_d;
      error_q       <= error_d;
      hours_q       <= hours_d;
      minutes_q     <= minutes_d;
      reset_shift_q <= reset_shift_d;
      load_time_q   <= load_time_d;
      load_alarm_q  <= load_alarm_d;
      busy_q        <= busy_d;
    end
  end

  assign keypad_reset_shift = reset_shift_q;
  assign load_time          = load_time_q;
  assign load_alarm         = load_alarm_q;
  assign hours_bcd          = hours_q;
  assign minutes_bcd        = minutes_q;
  assign digit_count        = count_q;
  assign entry_error        = error_q;
  assign busy               = busy_q;

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Consumer end of the keypad digit interface. It watches shift_pulse and the 4-digit BCD keypad_values word. It frames an HH:MM entry for either the clock time or the alarm time, validates it, and issues a one-cycle load to the timekeeping block. It also drives keypad_reset_shift to clear the keypad shift register at the start of every entry.

Parameters:
TIMEOUT_CYCLES, 1000, idle cycles between digits before an entry is abandoned (used only with the optional feature).
TMO_W, 10, width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
keypad_values  in  16  BCD digits; [15:12]=H tens, [11:8]=H units, [7:4]=M tens, [3:0]=M units
shift_pulse  in  1  one-cycle strobe, one per digit shifted into keypad_values
set_time_req  in  1  level/pulse; starts a clock-time entry
set_alarm_req  in  1  level/pulse; starts an alarm-time entry
confirm  in  1  one-cycle strobe; user pressed enter
cancel  in  1  one-cycle strobe; abort the current entry
keypad_reset_shift  out  1  one-cycle pulse that clears the keypad shift register
load_time  out  1  one-cycle pulse; hours/minutes valid for clock
load_alarm  out  1  one-cycle pulse; hours/minutes valid for alarm
hours_bcd  out  8  latched BCD hours
minutes_bcd  out  8  latched BCD minutes
digit_count  out  3  digits received in this entry, 0..4, saturating
entry_error  out  1  sticky error flag; cleared by the next request
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0; target register = TIME; timeout counter = 0.
- States and transitions:
  - IDLE -> ARM on set_time_req or set_alarm_req. If both are high, TIME wins. The target is latched and entry_error is cleared on this transition.
  - ARM -> COLLECT after exactly one cycle. keypad_reset_shift=1 only while in ARM. digit_count=0.
  - COLLECT: each shift_pulse increments digit_count, saturating at 4 (a 5th or later pulse is ignored for counting; keypad_values still reflects the last 4 digits).
    - confirm -> VALIDATE. If shift_pulse and confirm arrive in the same cycle, the pulse is counted first.
    - cancel -> IDLE without error. cancel has priority over confirm.
    - A new set_*_req while in COLLECT -> ARM with the new target (entry restarts).
  - VALIDATE (1 cycle): checks, all on keypad_values as sampled in this cycle:
    - digit_count==4;
    - every nibble <=9;
    - H tens <=2, and H <=23 (H tens==2 requires H units <=3);
    - M tens <=5.
    - Pass -> LOAD, with hours_bcd/minutes_bcd latched from keypad_values. Fail -> ERR.
  - LOAD (1 cycle): load_time or load_alarm =1 per the target. -> IDLE.
  - ERR (1 cycle): entry_error set (sticky). -> IDLE. hours_bcd/minutes_bcd are not modified.
- Latency: confirm sampled at edge k -> VALIDATE after k -> load pulse high during cycle k+2..k+3. Total 2 clocks.
- All outputs are registered or Moore-decoded from state; no combinational input-to-output path.
- Requests seen in VALIDATE, LOAD or ERR are ignored (not queued).
- hours_bcd/minutes_bcd hold their value between loads.
- rst_n asserted mid-entry aborts immediately; no load is issued.

Optional Feature:
ENTRY_TIMEOUT_EN
- Defined: in COLLECT a counter increments every cycle and clears on shift_pulse or on entry to COLLECT. When it reaches TIMEOUT_CYCLES the FSM goes to ERR (entry_error=1).
- Undefined: no counter is built and COLLECT waits indefinitely. TMO_W is unused.

Decomposition:
- Shared package keypad_pkg holds:
  - state encoding enum: IDLE, ARM, COLLECT, VALIDATE, LOAD, ERR;
  - target enum: TIME, ALARM;
  - constants MAX_HOUR_BCD=8'h23, MAX_MIN_TENS=4'd5, NUM_DIGITS=3'd4.
- One sub-module, bcd_time_check: combinational, takes the 16-bit word and returns valid. It is reused later for alarm compare sanity checks.

Test Plan:
1. set_time_req; 4 shift_pulses with keypad_values=16'h1245; confirm -> keypad_reset_shift one cycle after the request; load_time high 2 clocks after confirm; hours_bcd=8'h12, minutes_bcd=8'h45; load_alarm stays 0.
2. set_alarm_req; 4 pulses with values=16'h2360; confirm -> no load pulse, entry_error=1, hours/minutes unchanged; a following set_time_req clears entry_error.
3. set_time_req; 3 pulses with 16'h0123; confirm -> ERR (count 3 != 4). Then 6 pulses ending at 16'h0759; confirm -> digit_count=4, load_time, hours=8'h07, minutes=8'h59.
4. set_time_req and set_alarm_req in the same cycle; 4 pulses with 16'h0000; confirm -> load_time only. Next, cancel mid-entry -> IDLE, busy=0, no error.
5. shift_pulse (4th digit) and confirm in the same cycle, values=16'h2359 -> accepted, load issued. Also: rst_n low while in VALIDATE -> all outputs 0 and no load.
6. (ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES=20) set_time_req; 1 pulse; idle 20 cycles -> entry_error=1, IDLE. With the macro undefined -> still in COLLECT after 100 idle cycles.
